// File: rtl/hc_pkg.sv
// hc_pkg -- shared types and decode helpers for the HardCloud CSR bank.
//
// Contents:
//   - Reduced CCI-P MMIO types: request header, c0 Rx and c2 Tx structs.
//     Only the MMIO fields are modelled, and data is 64 bits wide.
//   - Byte addresses of the HardCloud registers and the HC_CONTROL action codes.
//   - t_hc_run_state (run-control states), t_hc_buffer (one descriptor),
//     t_hc_status (HC_STATUS layout).
//   - hc_buf_index / hc_decode / hc_is_wr: turn an MMIO dword address into a
//     register selector.
//
// Optional feature macro used by the bank: HC_CSR_READBACK_EN.
package hc_pkg;

    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mmioAddr;   // dword index (byte address >> 2)
    typedef logic [8:0]  t_ccip_tid;
    typedef logic [63:0] t_ccip_mmioData;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        t_ccip_mmioData      data;
        logic                mmioWrValid;
        logic                mmioRdValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    localparam int HC_MAX_BUFFERS = 16;

    // Byte addresses
    localparam logic [17:0] HC_STATUS_ADDR   = 18'h100;
    localparam logic [17:0] HC_DSM_BASE_ADDR = 18'h110;
    localparam logic [17:0] HC_CONTROL_ADDR  = 18'h118;
    localparam logic [17:0] HC_BUF_BASE_ADDR = 18'h120;

    // HC_CONTROL action values
    localparam logic [31:0] HC_CONTROL_RESET = 32'h0;
    localparam logic [31:0] HC_CONTROL_READY = 32'h1;
    localparam logic [31:0] HC_CONTROL_START = 32'h3;
    localparam logic [31:0] HC_CONTROL_STOP  = 32'h7;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } t_hc_run_state;

    typedef struct packed {
        t_ccip_clAddr addr;
        logic [31:0]  size;
    } t_hc_buffer;

    typedef struct packed {
        logic [43:0] rsvd;
        logic [15:0] buf_valid;
        logic        error;
        logic [2:0]  state;
    } t_hc_status;

    typedef enum logic [2:0] {
        HC_REG_NONE,
        HC_REG_STATUS,
        HC_REG_DSM,
        HC_REG_CONTROL,
        HC_REG_BUF_ADDR,
        HC_REG_BUF_SIZE
    } t_hc_reg;

    // Descriptor index of a dword address. Only meaningful once the byte
    // address is known to be at or above the descriptor base.
    function automatic logic [13:0] hc_buf_index(input t_ccip_mmioAddr dw);
        logic [17:0] offset;
        offset = {dw, 2'b00} - HC_BUF_BASE_ADDR;
        return offset[17:4];
    endfunction

    // Odd dwords never decode; descriptors past n_buffers decode to NONE.
    function automatic t_hc_reg hc_decode(input t_ccip_mmioAddr dw,
                                          input logic [13:0] n_buffers);
        logic [17:0] byte_addr;
        t_hc_reg     sel;
        byte_addr = {dw, 2'b00};
        sel       = HC_REG_NONE;
        if (!dw[0]) begin
            if (byte_addr == HC_STATUS_ADDR)
                sel = HC_REG_STATUS;
            else if (byte_addr == HC_DSM_BASE_ADDR)
                sel = HC_REG_DSM;
            else if (byte_addr == HC_CONTROL_ADDR)
                sel = HC_REG_CONTROL;
            else if (byte_addr >= HC_BUF_BASE_ADDR && hc_buf_index(dw) < n_buffers)
                // descriptor base is 16-byte aligned: bit 3 picks size over address
                sel = byte_addr[3] ? HC_REG_BUF_SIZE : HC_REG_BUF_ADDR;
        end
        return sel;
    endfunction

    function automatic logic hc_is_wr(input t_if_ccip_c0_Rx rx,
                                      input t_hc_reg target,
                                      input logic [13:0] n_buffers);
        return rx.mmioWrValid && (hc_decode(rx.hdr.address, n_buffers) == target);
    endfunction

endpackage

// File: rtl/hc_run_ctrl.sv
// hc_run_ctrl -- run-control sequencer behind HC_CONTROL.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ctrl_wr      a write to HC_CONTROL is present this cycle
//   ctrl_data    written control value (data[31:0])
//   done         datapath completion, only acted on in S_RUN
//   all_valid    every configured descriptor has address and size written
//   state        current run state (registered)
//   error        sticky start-refused flag, cleared by a reset command
//   start        one-cycle pulse on the cycle after entering S_RUN
//   running      high while in S_RUN
//   afu_rst_n    datapath soft reset, low while in S_RESET
//   clear_valid  combinational: descriptor valid flags must clear this cycle
module hc_run_ctrl
    import hc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ctrl_wr,
    input  logic [31:0]   ctrl_data,
    input  logic          done,
    input  logic          all_valid,
    output t_hc_run_state state,
    output logic          error,
    output logic          start,
    output logic          running,
    output logic          afu_rst_n,
    output logic          clear_valid
);

    t_hc_run_state state_reg, state_next;
    logic error_reg, error_next;
    logic start_reg, start_next;
    logic running_reg, running_next;
    logic afu_rst_n_reg, afu_rst_n_next;

    always_comb begin
        state_next  = state_reg;
        error_next  = error_reg;
        clear_valid = 1'b0;
        if (ctrl_wr) begin
            // A control write in the same cycle as done wins; done is dropped.
            case (ctrl_data)
                HC_CONTROL_RESET: begin
                    state_next  = S_RESET;
                    error_next  = 1'b0;
                    clear_valid = 1'b1;
                end
                HC_CONTROL_READY: begin
                    if (state_reg inside {S_RESET, S_STOP, S_DONE})
                        state_next = S_READY;
                end
                HC_CONTROL_START: begin
                    if (state_reg == S_READY) begin
                        if (all_valid)
                            state_next = S_RUN;
                        else
                            error_next = 1'b1;
                    end
                end
                HC_CONTROL_STOP: begin
                    if (state_reg == S_RUN)
                        state_next = S_STOP;
                end
                default: ;
            endcase
        end else if (done && state_reg == S_RUN) begin
            state_next = S_DONE;
        end

        // Outputs are registered from the next state so they line up with it.
        start_next     = (state_next == S_RUN) && (state_reg != S_RUN);
        running_next   = (state_next == S_RUN);
        afu_rst_n_next = (state_next != S_RESET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_RESET;
            error_reg     <= 1'b0;
            start_reg     <= 1'b0;
            running_reg   <= 1'b0;
            afu_rst_n_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            error_reg     <= error_next;
            start_reg     <= start_next;
            running_reg   <= running_next;
            afu_rst_n_reg <= afu_rst_n_next;
        end
    end

    assign state     = state_reg;
    assign error     = error_reg;
    assign start     = start_reg;
    assign running   = running_reg;
    assign afu_rst_n = afu_rst_n_reg;

endmodule

// File: rtl/hc_csr_bank.sv
// hc_csr_bank -- HardCloud MMIO register bank and run-control sequencer.
//
// Decodes MMIO writes/reads from CCI-P channel 0 and answers reads on
// channel 2 one cycle later, with no stalls and no buffering.
// Register map (byte addresses):
//   0x100   HC_STATUS (RO)  [2:0] state, [3] error, [19:4] buf_valid
//   0x110   HC_DSM_BASE_LOW
//   0x118   HC_CONTROL
//   0x120+0x10*i / +0x8   descriptor i address / size
//
// Parameters: N_BUFFERS (1..16) descriptor count.
// Macro: HC_CSR_READBACK_EN -- when defined, reads return the DSM,
//   control and descriptor contents. Otherwise only HC_STATUS returns data,
//   and every other read returns 0 with the same timing.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   c0_rx       MMIO requests        c2_tx     MMIO read responses
//   dsm_base    DSM cache-line addr  buf_addr  / buf_size  descriptors
//   afu_rst_n   datapath soft reset  start     one-cycle run pulse
//   running     high in S_RUN        done      datapath completion
module hc_csr_bank
    import hc_pkg::*;
#(
    parameter int N_BUFFERS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  t_if_ccip_c0_Rx                c0_rx,
    output t_if_ccip_c2_Tx                c2_tx,
    output t_ccip_clAddr                  dsm_base,
    output t_ccip_clAddr [N_BUFFERS-1:0]  buf_addr,
    output logic [N_BUFFERS-1:0][31:0]    buf_size,
    output logic                          afu_rst_n,
    output logic                          start,
    output logic                          running,
    input  logic                          done
);

    localparam logic [13:0] N_BUF = 14'(N_BUFFERS);

    logic            wr_dsm, wr_ctrl, wr_buf_addr, wr_buf_size;
    t_hc_reg         rd_sel;
    logic [13:0]     buf_idx;
    t_ccip_clAddr    dsm_base_reg;
    t_hc_buffer [HC_MAX_BUFFERS-1:0] buf_all;
    logic [HC_MAX_BUFFERS-1:0]       buf_valid_all;
    logic            all_valid;
    logic            clear_valid;
    t_hc_run_state   state;
    logic            error;
    t_hc_status      status;
    t_ccip_mmioData  rd_data_next;
    t_if_ccip_c2_Tx  c2_tx_reg;
    logic            unused_ok;

    assign unused_ok = ^{c0_rx.hdr.length, c0_rx.hdr.rsvd, c0_rx.data[63:42]};

    assign wr_dsm      = hc_is_wr(c0_rx, HC_REG_DSM, N_BUF);
    assign wr_ctrl     = hc_is_wr(c0_rx, HC_REG_CONTROL, N_BUF);
    assign wr_buf_addr = hc_is_wr(c0_rx, HC_REG_BUF_ADDR, N_BUF);
    assign wr_buf_size = hc_is_wr(c0_rx, HC_REG_BUF_SIZE, N_BUF);
    assign rd_sel      = hc_decode(c0_rx.hdr.address, N_BUF);
    assign buf_idx     = hc_buf_index(c0_rx.hdr.address);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dsm_base_reg <= '0;
        else if (wr_dsm)
            dsm_base_reg <= c0_rx.data[41:0];
    end

    // Descriptor table padded to the maximum size, so the read mux can
    // index it with a fixed-width selector. Entries past N_BUFFERS are 0.
    genvar gi;
    generate
        for (gi = 0; gi < HC_MAX_BUFFERS; gi++) begin : g_buf
            if (gi < N_BUFFERS) begin : g_used
                t_hc_buffer buf_reg;
                logic       addr_seen_reg;
                logic       size_seen_reg;
                logic       hit;

                assign hit = (buf_idx == 14'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        buf_reg       <= '0;
                        addr_seen_reg <= 1'b0;
                        size_seen_reg <= 1'b0;
                    end else begin
                        if (wr_buf_addr && hit) begin
                            buf_reg.addr  <= c0_rx.data[41:0];
                            addr_seen_reg <= 1'b1;
                        end
                        if (wr_buf_size && hit) begin
                            buf_reg.size  <= c0_rx.data[31:0];
                            size_seen_reg <= 1'b1;
                        end
                        // clear_valid only fires on a control write, so it
                        // never collides with a descriptor write.
                        if (clear_valid) begin
                            addr_seen_reg <= 1'b0;
                            size_seen_reg <= 1'b0;
                        end
                    end
                end

                assign buf_all[gi]       = buf_reg;
                assign buf_valid_all[gi] = addr_seen_reg & size_seen_reg;
                assign buf_addr[gi]      = buf_reg.addr;
                assign buf_size[gi]      = buf_reg.size;
            end else begin : g_unused
                assign buf_all[gi]       = '0;
                assign buf_valid_all[gi] = 1'b0;
            end
        end
    endgenerate

    assign all_valid = &buf_valid_all[N_BUFFERS-1:0];

    hc_run_ctrl u_run_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_wr     (wr_ctrl),
        .ctrl_data   (c0_rx.data[31:0]),
        .done        (done),
        .all_valid   (all_valid),
        .state       (state),
        .error       (error),
        .start       (start),
        .running     (running),
        .afu_rst_n   (afu_rst_n),
        .clear_valid (clear_valid)
    );

    always_comb begin
        status           = '0;
        status.state     = state;
        status.error     = error;
        status.buf_valid = buf_valid_all;
    end

`ifdef HC_CSR_READBACK_EN
    logic [31:0] control_reg;
    logic [3:0]  buf_sel;

    assign buf_sel = buf_idx[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            control_reg <= '0;
        else if (wr_ctrl)
            control_reg <= c0_rx.data[31:0];
    end
`endif

    // Read data comes from register state before this cycle's write lands.
    always_comb begin
        rd_data_next = '0;
        case (rd_sel)
            HC_REG_STATUS:   rd_data_next = status;
`ifdef HC_CSR_READBACK_EN
            HC_REG_DSM:      rd_data_next = 64'(dsm_base_reg);
            HC_REG_CONTROL:  rd_data_next = 64'(control_reg);
            HC_REG_BUF_ADDR: rd_data_next = 64'(buf_all[buf_sel].addr);
            HC_REG_BUF_SIZE: rd_data_next = 64'(buf_all[buf_sel].size);
`endif
            default:         rd_data_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c2_tx_reg <= '0;
        end else begin
            c2_tx_reg.mmioRdValid <= c0_rx.mmioRdValid;
            c2_tx_reg.hdr.tid     <= c0_rx.mmioRdValid ? c0_rx.hdr.tid : '0;
            c2_tx_reg.data        <= c0_rx.mmioRdValid ? rd_data_next : '0;
        end
    end

    assign c2_tx    = c2_tx_reg;
    assign dsm_base = dsm_base_reg;

endmodule

// File: tb/tb_hc_csr_bank.sv
// tb_hc_csr_bank -- self-checking bench for hc_csr_bank (N_BUFFERS = 4).
// A register-map model kept in plain arrays predicts every output after
// each driven cycle; directed literal checks pin the model; a random
// phase exercises the map, the control sequencer, done and collisions.
// Honours HC_CSR_READBACK_EN in the same way as the design.
module tb_hc_csr_bank;
    import hc_pkg::*;

    localparam int NB = 4;
    localparam int ST_RESET = 0, ST_READY = 1, ST_RUN = 2, ST_STOP = 3, ST_DONE = 4;
`ifdef HC_CSR_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic done = 1'b0;
    t_if_ccip_c0_Rx c0_rx;
    t_if_ccip_c2_Tx c2_tx;
    t_ccip_clAddr dsm_base;
    t_ccip_clAddr [NB-1:0] buf_addr;
    logic [NB-1:0][31:0] buf_size;
    logic afu_rst_n, start, running;

    int n_vec = 0;
    int n_miss = 0;
    bit step_pending = 1'b0;

    always #5 clk = ~clk;

    hc_csr_bank #(.N_BUFFERS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .c0_rx(c0_rx), .c2_tx(c2_tx),
        .dsm_base(dsm_base), .buf_addr(buf_addr), .buf_size(buf_size),
        .afu_rst_n(afu_rst_n), .start(start), .running(running), .done(done)
    );

    // ---------------- reference model ----------------
    logic [41:0] m_dsm;
    logic [31:0] m_ctrl;
    logic [41:0] m_addr [NB];
    logic [31:0] m_size [NB];
    bit          m_aw [NB];
    bit          m_sw [NB];
    int          m_state;
    bit          m_err, m_start, m_running, m_afu;
    bit          e_rd_valid;
    logic [8:0]  e_tid;
    logic [63:0] e_data;

    function automatic void model_reset();
        m_dsm = '0; m_ctrl = '0;
        for (int k = 0; k < NB; k++) begin
            m_addr[k] = '0; m_size[k] = '0; m_aw[k] = 1'b0; m_sw[k] = 1'b0;
        end
        m_state = ST_RESET; m_err = 1'b0;
        m_start = 1'b0; m_running = 1'b0; m_afu = 1'b0;
        e_rd_valid = 1'b0; e_tid = '0; e_data = '0;
    endfunction

    function automatic bit model_all_valid();
        for (int k = 0; k < NB; k++)
            if (!(m_aw[k] && m_sw[k])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] model_read(input logic [15:0] dw);
        int b;
        int v;
        b = int'(dw) * 4;
        v = 0;
        if (dw[0]) return 64'd0;
        if (b == 'h100) begin
            for (int k = 0; k < NB; k++)
                if (m_aw[k] && m_sw[k]) v += (1 << k);
            return 64'(m_state) + (64'(m_err) << 3) + (64'(v) << 4);
        end
        if (RB) begin
            if (b == 'h110) return 64'(m_dsm);
            if (b == 'h118) return 64'(m_ctrl);
            if (b >= 'h120 && (b - 'h120) / 16 < NB) begin
                if ((b - 'h120) % 16 == 0) return 64'(m_addr[(b - 'h120) / 16]);
                return 64'(m_size[(b - 'h120) / 16]);
            end
        end
        return 64'd0;
    endfunction

    function automatic void model_control(input logic [31:0] v);
        if (v == 0) begin
            m_state = ST_RESET; m_err = 1'b0;
            for (int k = 0; k < NB; k++) begin m_aw[k] = 1'b0; m_sw[k] = 1'b0; end
        end else if (v == 1) begin
            if (m_state == ST_RESET || m_state == ST_STOP || m_state == ST_DONE)
                m_state = ST_READY;
        end else if (v == 3) begin
            if (m_state == ST_READY) begin
                if (model_all_valid()) m_state = ST_RUN;
                else m_err = 1'b1;
            end
        end else if (v == 7) begin
            if (m_state == ST_RUN) m_state = ST_STOP;
        end
    endfunction

    function automatic void model_step(input bit wr, input bit rd, input logic [15:0] dw,
                                       input logic [63:0] data, input logic [8:0] tid,
                                       input bit dn);
        int b;
        int old;
        bit ctrl_hit;
        old = m_state;
        b = int'(dw) * 4;
        e_rd_valid = rd;
        e_tid  = tid;
        e_data = rd ? model_read(dw) : 64'd0;
        ctrl_hit = wr && !dw[0] && b == 'h118;
        if (wr && !dw[0]) begin
            if (b == 'h110) m_dsm = data[41:0];
            else if (ctrl_hit) begin m_ctrl = data[31:0]; model_control(data[31:0]); end
            else if (b >= 'h120 && (b - 'h120) / 16 < NB) begin
                if ((b - 'h120) % 16 == 0) begin
                    m_addr[(b - 'h120) / 16] = data[41:0]; m_aw[(b - 'h120) / 16] = 1'b1;
                end else begin
                    m_size[(b - 'h120) / 16] = data[31:0]; m_sw[(b - 'h120) / 16] = 1'b1;
                end
            end
        end
        if (!ctrl_hit && dn && old == ST_RUN) m_state = ST_DONE;
        m_start   = (m_state == ST_RUN) && (old != ST_RUN);
        m_running = (m_state == ST_RUN);
        m_afu     = (m_state != ST_RESET);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("rd_valid", 64'(c2_tx.mmioRdValid), 64'(e_rd_valid));
        if (e_rd_valid) begin
            check("rd_tid", 64'(c2_tx.hdr.tid), 64'(e_tid));
            check("rd_data", c2_tx.data, e_data);
        end
        check("dsm_base", 64'(dsm_base), 64'(m_dsm));
        for (int k = 0; k < NB; k++) begin
            check("buf_addr", 64'(buf_addr[k]), 64'(m_addr[k]));
            check("buf_size", 64'(buf_size[k]), 64'(m_size[k]));
        end
        check("afu_rst_n", 64'(afu_rst_n), 64'(m_afu));
        check("start", 64'(start), 64'(m_start));
        check("running", 64'(running), 64'(m_running));
    endtask

    // Compare process: runs after every edge that followed a modelled drive.
    always begin
        @(posedge clk);
        if (step_pending) begin
            step_pending = 1'b0;
            #1;
            compare_all();
        end
    end

    task automatic step(input bit wr, input bit rd, input logic [15:0] dw,
                        input logic [63:0] data, input logic [8:0] tid, input bit dn);
        @(negedge clk);
        c0_rx = '0;
        c0_rx.mmioWrValid = wr;
        c0_rx.mmioRdValid = rd;
        c0_rx.hdr.address = dw;
        c0_rx.hdr.tid     = tid;
        c0_rx.data        = data;
        done              = dn;
        model_step(wr, rd, dw, data, tid, dn);
        step_pending = 1'b1;
        $display("[%0t] wr=%0b rd=%0b byte=0x%03h data=0x%0h tid=%0d done=%0b",
                 $time, wr, rd, {dw, 2'b00}, data, tid, dn);
        @(posedge clk);
        #2;
        c0_rx = '0;
        done  = 1'b0;
    endtask

    task automatic wr_reg(input int byte_addr, input logic [63:0] data);
        step(1'b1, 1'b0, 16'(byte_addr / 4), data, 9'd0, 1'b0);
    endtask

    task automatic rd_reg(input int byte_addr, input logic [8:0] tid);
        step(1'b0, 1'b1, 16'(byte_addr / 4), 64'd0, tid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ctl_vals [8];
        int r, sel;
        bit wr, rd, dn;
        logic [15:0] dw;
        logic [63:0] data;

        ctl_vals = '{32'h1, 32'h3, 32'h3, 32'h7, 32'h0, 32'h1, 32'h3, 32'h5};
        c0_rx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_valid", 64'(c2_tx.mmioRdValid), 64'd0);
        check("reset_afu_rst_n", 64'(afu_rst_n), 64'd0);
        check("reset_running", 64'(running), 64'd0);
        check("reset_buf_addr0", 64'(buf_addr[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // status read right after reset
        rd_reg('h100, 9'h5);
        check("status_rst_valid", 64'(c2_tx.mmioRdValid), 64'd1);
        check("status_rst_tid", 64'(c2_tx.hdr.tid), 64'h5);
        check("status_rst_data", c2_tx.data, 64'h0);

        // configure all addresses, sizes except buffer 2's
        for (int i = 0; i < NB; i++) wr_reg('h120 + 'h10 * i, 64'h1000 + 64'(i));
        for (int i = 0; i < NB; i++) if (i != 2) wr_reg('h128 + 'h10 * i, 64'(64 * i));
        wr_reg('h118, 64'h1);
        wr_reg('h118, 64'h3);
        check("refused_start", 64'(start), 64'd0);
        rd_reg('h100, 9'h1);
        check("status_refused", c2_tx.data, 64'hB9);

        // complete config and start
        wr_reg('h128 + 'h20, 64'd128);
        wr_reg('h118, 64'h3);
        check("start_pulse", 64'(start), 64'd1);
        check("running_on", 64'(running), 64'd1);
        step(1'b0, 1'b0, 16'd0, 64'd0, 9'd0, 1'b0);
        check("start_one_cycle", 64'(start), 64'd0);
        for (int i = 0; i < NB; i++) begin
            check("buf_addr_lit", 64'(buf_addr[i]), 64'h1000 + 64'(i));
            check("buf_size_lit", 64'(buf_size[i]), 64'(64 * i));
            rd_reg('h120 + 'h10 * i, 9'(i));
            check("rb_addr", c2_tx.data, RB ? 64'h1000 + 64'(i) : 64'd0);
            rd_reg('h128 + 'h10 * i, 9'(i + 8));
            check("rb_size", c2_tx.data, RB ? 64'(64 * i) : 64'd0);
        end

        // done in S_RUN
        step(1'b0, 1'b0, 16'd0, 64'd0, 9'd0, 1'b1);
        check("done_running", 64'(running), 64'd0);
        rd_reg('h100, 9'h2);
        check("status_done", c2_tx.data, 64'hFC);

        // stop and done in the same cycle: stop wins
        wr_reg('h118, 64'h1);
        wr_reg('h118, 64'h3);
        step(1'b1, 1'b0, 16'('h118 / 4), 64'h7, 9'd0, 1'b1);
        check("stop_running", 64'(running), 64'd0);
        rd_reg('h100, 9'h3);
        check("status_stop", c2_tx.data, 64'hFB);

        // asynchronous reset while running, with a read in flight
        wr_reg('h118, 64'h1);
        wr_reg('h118, 64'h3);
        @(negedge clk);
        c0_rx = '0;
        c0_rx.mmioRdValid = 1'b1;
        c0_rx.hdr.address = 16'('h100 / 4);
        c0_rx.hdr.tid     = 9'h9;
        #2 rst_n = 1'b0;
        #1;
        check("arst_afu_rst_n", 64'(afu_rst_n), 64'd0);
        check("arst_running", 64'(running), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_no_response", 64'(c2_tx.mmioRdValid), 64'd0);
        check("arst_buf_addr1", 64'(buf_addr[1]), 64'd0);
        check("arst_dsm", 64'(dsm_base), 64'd0);
        @(negedge clk);
        c0_rx = '0;
        rst_n = 1'b1;

        // DSM write, odd-dword and out-of-range descriptor writes, read/write collision
        wr_reg('h110, 64'hABCDE);
        check("dsm_lit", 64'(dsm_base), 64'hABCDE);
        wr_reg('h114, 64'h55);
        wr_reg('h120 + 'h10 * NB, 64'h77);
        step(1'b1, 1'b1, 16'('h110 / 4), 64'h12345, 9'h7, 1'b0);
        check("rd_old_value", c2_tx.data, RB ? 64'hABCDE : 64'd0);

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 9);
            wr = (r < 5);
            rd = (r >= 3 && r < 8);
            sel = $urandom_range(0, 9);
            case (sel)
                0: dw = 16'h40;
                1: dw = 16'h41;
                2: dw = 16'h44;
                3: dw = 16'h42;
                4, 5: dw = 16'h46;
                default: dw = 16'h48 + 16'($urandom_range(0, 23));
            endcase
            if (dw == 16'h46) data = 64'(ctl_vals[$urandom_range(0, 7)]);
            else data = {$urandom, $urandom};
            dn = ($urandom_range(0, 7) == 0);
            step(wr, rd, dw, data, 9'($urandom_range(0, 511)), dn);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
